icache_refill_ctrl: RTL and testbench

Sequencer for instruction-cache line refills in the fetch stage. When the fetch stage reports a miss (`Imiss`), the block stalls the fetch pipeline and requests the aligned line from memory. It streams the returned words into the instruction cache data array and validates the line with a tag write. It sits between the fetch stage, the hazard unit (which it feeds a stall) and the memory port.

---
 rtl/icache_refill_ctrl_pkg.sv | 23 ++
 rtl/icache_refill_ctrl.sv | 110 +++++++++++
 tb/tb_icache_refill_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
// rtl/icache_refill_ctrl_pkg.sv - shared fetch-stage types and constants for the refill sequencer
package icache_refill_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_FILL   = 2'd2;
  localparam logic [1:0] ST_COMMIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    REQ    = ST_REQ,
    FILL   = ST_FILL,
    COMMIT = ST_COMMIT
  } refill_state_e;

  localparam int DEF_LINE_WORDS = 4;

  // Byte-offset bits inside one line of 32-bit words.
  function automatic int line_off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - stalls fetch on an I-cache miss and streams the aligned line into the cache
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Imiss,
  input  logic [ADDR_W-1:0] MissAddr,
  input  logic              FlushPipeandPC,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic              MemValid,
  input  logic [31:0]       MemData,
  output logic              CacheWE,
  output logic [ADDR_W-1:0] CacheWAddr,
  output logic [31:0]       CacheWData,
  output logic              CacheTagWE,
  output logic              RefillStall,
  output logic              RefillDone,
  output logic [31:0]       MissCount
);

  localparam int                CNT_W     = $clog2(LINE_WORDS);
  localparam int                OFF_W     = line_off_w(LINE_WORDS);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  refill_state_e     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       miss_count_q, miss_count_d;
  logic              miss_start;

  // A miss that coincides with a redirect is stale and must not start a refill.
  assign miss_start = Imiss & ~FlushPipeandPC;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      cnt_q        <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      miss_count_q <= miss_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    miss_count_d = miss_count_q;
    MemReq       = 1'b0;
    CacheWE      = 1'b0;
    CacheTagWE   = 1'b0;
    RefillDone   = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_start) begin
          base_d  = MissAddr & BASE_MASK;
          state_d = REQ;
        end
      end
      REQ: begin
        MemReq = 1'b1;
        if (MemAck) begin
          cnt_d   = '0;
          state_d = FILL;
        end else if (FlushPipeandPC) begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // Redirects are ignored here: the burst is already in flight and its data is valid.
        if (MemValid) begin
          CacheWE = 1'b1;
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = COMMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      COMMIT: begin
        CacheTagWE = 1'b1;
        RefillDone = 1'b1;
        if (miss_count_q != 32'hFFFF_FFFF) begin
          miss_count_d = miss_count_q + 32'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign MemAddr     = base_q;
  assign CacheWAddr  = base_q + (ADDR_W'(cnt_q) << 2);
  assign CacheWData  = MemData;
  assign RefillStall = (state_q != IDLE) | miss_start;
  assign MissCount   = miss_count_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl
module tb_icache_refill_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Imiss;
  logic [31:0] MissAddr;
  logic        FlushPipeandPC;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemAck;
  logic        MemValid;
  logic [31:0] MemData;
  logic        CacheWE;
  logic [31:0] CacheWAddr;
  logic [31:0] CacheWData;
  logic        CacheTagWE;
  logic        RefillStall;
  logic        RefillDone;
  logic [31:0] MissCount;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int we_cnt = 0;

  always #5 Clk = ~Clk;

  icache_refill_ctrl #(.LINE_WORDS(4), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .Imiss(Imiss), .MissAddr(MissAddr),
    .FlushPipeandPC(FlushPipeandPC), .MemReq(MemReq), .MemAddr(MemAddr),
    .MemAck(MemAck), .MemValid(MemValid), .MemData(MemData),
    .CacheWE(CacheWE), .CacheWAddr(CacheWAddr), .CacheWData(CacheWData),
    .CacheTagWE(CacheTagWE), .RefillStall(RefillStall), .RefillDone(RefillDone),
    .MissCount(MissCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    Imiss = 1'b0; MissAddr = '0; FlushPipeandPC = 1'b0;
    MemAck = 1'b0; MemValid = 1'b0; MemData = '0;
  endtask

  task automatic beat(input logic [31:0] waddr, input logic [31:0] data);
    MemValid = 1'b1; MemData = data; #1;
    chk("beat_we", {31'd0, CacheWE}, 32'd1);
    chk("beat_waddr", CacheWAddr, waddr);
    chk("beat_wdata", CacheWData, data);
    chk("beat_tagwe", {31'd0, CacheTagWE}, 32'd0);
    next_cyc();
    MemValid = 1'b0;
  endtask

  task automatic do_refill(input logic [31:0] addr, input logic [31:0] exp_base,
                           input logic [31:0] data0, input logic [31:0] exp_cnt);
    Imiss = 1'b1; MissAddr = addr; #1;
    chk("rf_stall_c0", {31'd0, RefillStall}, 32'd1);
    chk("rf_memreq_c0", {31'd0, MemReq}, 32'd0);
    next_cyc();
    MemAck = 1'b1; #1;
    chk("rf_memreq_c1", {31'd0, MemReq}, 32'd1);
    chk("rf_memaddr", MemAddr, exp_base);
    next_cyc();
    MemAck = 1'b0;
    for (int i = 0; i < 4; i++) beat(exp_base + 32'(4 * i), data0 + 32'(i));
    #1;
    chk("rf_tagwe", {31'd0, CacheTagWE}, 32'd1);
    chk("rf_done", {31'd0, RefillDone}, 32'd1);
    chk("rf_stall_commit", {31'd0, RefillStall}, 32'd1);
    next_cyc();
    Imiss = 1'b0; #1;
    chk("rf_stall_release", {31'd0, RefillStall}, 32'd0);
    chk("rf_memreq_after", {31'd0, MemReq}, 32'd0);
    chk("rf_tagwe_after", {31'd0, CacheTagWE}, 32'd0);
    chk("rf_misscount", MissCount, exp_cnt);
  endtask

  initial begin
    idle_in();
    Rst = 1'b1;
    next_cyc();
    chk("rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("rst_we", {31'd0, CacheWE}, 32'd0);
    chk("rst_tagwe", {31'd0, CacheTagWE}, 32'd0);
    chk("rst_done", {31'd0, RefillDone}, 32'd0);
    chk("rst_count", MissCount, 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_stall_lo", {31'd0, RefillStall}, 32'd0);
    Imiss = 1'b1; #1;
    chk("rst_stall_follow", {31'd0, RefillStall}, 32'd1);
    Imiss = 1'b0;
    next_cyc();
    Rst = 1'b0;

    // Basic refill: 0x1238 -> line 0x1230, beats A0..A3
    next_cyc();
    do_refill(32'h0000_1238, 32'h0000_1230, 32'h0000_00A0, 32'd1);

    // Gapped: ack after 3 REQ cycles, one idle cycle between beats
    next_cyc();
    Imiss = 1'b1; MissAddr = 32'h0000_2004; #1;
    next_cyc();
    for (int j = 0; j < 3; j++) begin
      MemValid = (j == 1); #1;
      chk("gap_req_hold", {31'd0, MemReq}, 32'd1);
      chk("gap_req_addr", MemAddr, 32'h0000_2000);
      chk("gap_req_nowe", {31'd0, CacheWE}, 32'd0);
      next_cyc();
    end
    MemValid = 1'b0; MemAck = 1'b1; #1;
    next_cyc();
    MemAck = 1'b0;
    for (int k = 0; k < 7; k++) begin
      MemValid = (k % 2 == 0); MemData = 32'h0000_00B0 + 32'(k / 2); #1;
      if (CacheWE) we_cnt++;
      chk("gap_we", {31'd0, CacheWE}, {31'd0, (k % 2 == 0)});
      if (k % 2 == 0) chk("gap_waddr", CacheWAddr, 32'h0000_2000 + 32'(4 * (k / 2)));
      chk("gap_tagwe", {31'd0, CacheTagWE}, 32'd0);
      next_cyc();
    end
    MemValid = 1'b0; #1;
    chk("gap_commit", {31'd0, CacheTagWE}, 32'd1);
    chk("gap_we_count", 32'(we_cnt), 32'd4);
    next_cyc();
    Imiss = 1'b0; #1;
    chk("gap_count", MissCount, 32'd2);
    chk("gap_stall", {31'd0, RefillStall}, 32'd0);

    // Flush in REQ without ack aborts
    next_cyc();
    Imiss = 1'b1; MissAddr = 32'h0000_3008; #1;
    next_cyc();
    FlushPipeandPC = 1'b1; #1;
    chk("fl_req", {31'd0, MemReq}, 32'd1);
    next_cyc();
    Imiss = 1'b0; FlushPipeandPC = 1'b0; MemValid = 1'b1; MemData = 32'hDEAD; #1;
    chk("fl_idle_memreq", {31'd0, MemReq}, 32'd0);
    chk("fl_idle_we", {31'd0, CacheWE}, 32'd0);
    chk("fl_idle_stall", {31'd0, RefillStall}, 32'd0);
    next_cyc();
    MemValid = 1'b0; #1;
    chk("fl_tagwe", {31'd0, CacheTagWE}, 32'd0);
    chk("fl_count", MissCount, 32'd2);
    Imiss = 1'b1; FlushPipeandPC = 1'b1; #1;
    chk("fl_miss_stall", {31'd0, RefillStall}, 32'd0);
    next_cyc();
    Imiss = 1'b0; FlushPipeandPC = 1'b0; #1;
    chk("fl_miss_nostart", {31'd0, MemReq}, 32'd0);

    // Flush together with ack, held through the burst
    next_cyc();
    Imiss = 1'b1; MissAddr = 32'h0000_4010; #1;
    next_cyc();
    MemAck = 1'b1; FlushPipeandPC = 1'b1; #1;
    next_cyc();
    MemAck = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'h0000_4010 + 32'(4 * i), 32'h0000_00C0 + 32'(i));
    #1;
    chk("flack_tagwe", {31'd0, CacheTagWE}, 32'd1);
    next_cyc();
    Imiss = 1'b0; FlushPipeandPC = 1'b0; #1;
    chk("flack_count", MissCount, 32'd3);

    // Flush mid-FILL, including on an idle beat cycle
    next_cyc();
    Imiss = 1'b1; MissAddr = 32'h0000_501C; #1;
    next_cyc();
    MemAck = 1'b1; #1;
    next_cyc();
    MemAck = 1'b0;
    beat(32'h0000_5010, 32'h0000_00D0);
    beat(32'h0000_5014, 32'h0000_00D1);
    FlushPipeandPC = 1'b1; #1;
    chk("flfill_gap_we", {31'd0, CacheWE}, 32'd0);
    chk("flfill_stall", {31'd0, RefillStall}, 32'd1);
    next_cyc();
    beat(32'h0000_5018, 32'h0000_00D2);
    FlushPipeandPC = 1'b0;
    beat(32'h0000_501C, 32'h0000_00D3);
    #1;
    chk("flfill_tagwe", {31'd0, CacheTagWE}, 32'd1);
    next_cyc();
    Imiss = 1'b0; #1;
    chk("flfill_count", MissCount, 32'd4);

    // Reset after two beats
    next_cyc();
    Imiss = 1'b1; MissAddr = 32'h0000_6008; #1;
    next_cyc();
    MemAck = 1'b1; #1;
    next_cyc();
    MemAck = 1'b0;
    beat(32'h0000_6000, 32'h0000_00E0);
    beat(32'h0000_6004, 32'h0000_00E1);
    Imiss = 1'b0; Rst = 1'b1; MemValid = 1'b1; #1;
    chk("mrst_we", {31'd0, CacheWE}, 32'd0);
    chk("mrst_memreq", {31'd0, MemReq}, 32'd0);
    chk("mrst_tagwe", {31'd0, CacheTagWE}, 32'd0);
    chk("mrst_done", {31'd0, RefillDone}, 32'd0);
    chk("mrst_memaddr", MemAddr, 32'd0);
    chk("mrst_count", MissCount, 32'd0);
    chk("mrst_stall", {31'd0, RefillStall}, 32'd0);
    next_cyc();
    Rst = 1'b0; MemValid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("mrst_no_tag", {31'd0, CacheTagWE}, 32'd0);
      chk("mrst_no_req", {31'd0, MemReq}, 32'd0);
      next_cyc();
    end
    do_refill(32'h0000_7004, 32'h0000_7000, 32'h0000_00F0, 32'd1);

    // Saturation
    next_cyc();
    force dut.miss_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.miss_count_q;
    #1;
    chk("sat_preload", MissCount, 32'hFFFF_FFFE);
    next_cyc();
    do_refill(32'h0000_8000, 32'h0000_8000, 32'h0000_0010, 32'hFFFF_FFFF);
    next_cyc();
    do_refill(32'h0000_9004, 32'h0000_9000, 32'h0000_0020, 32'hFFFF_FFFF);

    next_cyc();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
